// File: rtl/mm2s_banked.sv
// Streams len*N words from N interleaved banks onto AXI-stream; first rd_en 1 cycle and first tvalid 3 cycles after start.
// Reads throttle against a 2-entry output buffer under tready backpressure. Define MM2S_BEAT_COUNT_EN to add beat_count.
module mm2s_banked #(
    parameter int D_W    = 8,
    parameter int N      = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [N-1:0]      rd_en,
    input  logic [N*D_W-1:0]  rd_data,
    output logic [D_W-1:0]    m_axis_mm2s_tdata,
    output logic              m_axis_mm2s_tvalid,
    input  logic              m_axis_mm2s_tready,
    output logic              m_axis_mm2s_tlast,
    output logic              busy,
    output logic              done
`ifdef MM2S_BEAT_COUNT_EN
    ,
    output logic [31:0]       beat_count
`endif
);
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic           last;
        logic [D_W-1:0] dat;
    } beat_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, addr_q;
    logic [BW-1:0]     bank_q, fl_bank_q;
    logic              fl_vld_q, fl_last_q;
    beat_t             buf_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              done_zero_q;
    logic              accept, issue, last_rd, pop, done_drain;
    logic [2:0]        occ, cap;
    logic [D_W-1:0]    rdat;
    beat_t             head;

    assign head               = buf_q[rd_ptr_q];
    assign m_axis_mm2s_tvalid = (cnt_q != 2'd0);
    assign m_axis_mm2s_tdata  = head.dat;
    assign m_axis_mm2s_tlast  = m_axis_mm2s_tvalid & head.last;
    assign pop                = m_axis_mm2s_tvalid & m_axis_mm2s_tready;

    assign accept  = (state_q == IDLE) && start && (len != '0);
    assign last_rd = (bank_q == BW'(N - 1)) && (addr_q == len_q - ADDR_W'(1));
    // Buffered plus in-flight words, less the word leaving now, must stay below 2.
    assign occ     = {1'b0, cnt_q} + {2'b0, fl_vld_q};
    assign cap     = 3'd2 + {2'b0, pop};
    assign issue   = (state_q == RUN) && (occ < cap);

    assign rd_addr = addr_q;
    assign rd_en   = issue ? (N'(1) << bank_q) : '0;
    assign rdat    = rd_data[fl_bank_q*D_W +: D_W];
    assign busy    = (state_q != IDLE);
    assign done    = done_drain | done_zero_q;

    always_comb begin
        state_d    = state_q;
        done_drain = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (issue && last_rd) state_d = DRAIN;
            DRAIN: begin
                if (cnt_q == 2'd0 && !fl_vld_q) begin
                    state_d    = IDLE;
                    done_drain = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            bank_q      <= '0;
            fl_vld_q    <= 1'b0;
            fl_last_q   <= 1'b0;
            fl_bank_q   <= '0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_zero_q <= (state_q == IDLE) && start && (len == '0);
            fl_vld_q    <= issue;
            fl_last_q   <= issue && last_rd;
            fl_bank_q   <= bank_q;
            if (accept) begin
                len_q  <= len;
                addr_q <= '0;
                bank_q <= '0;
            end else if (issue && !last_rd) begin
                // Counters freeze on the final read, so len = 2^ADDR_W-1 never wraps.
                if (bank_q == BW'(N - 1)) begin
                    bank_q <= '0;
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
                    bank_q <= bank_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (fl_vld_q) begin
                buf_q[wr_ptr_q] <= {fl_last_q, rdat};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, fl_vld_q} - {1'b0, pop};
        end
    end

`ifdef MM2S_BEAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      beat_count <= '0;
        else if (accept) beat_count <= '0;
        else if (pop)    beat_count <= beat_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mm2s_banked.sv
// Directed bench for mm2s_banked: N=4 banks where bank k address a holds 16*k+a.
module tb_mm2s_banked;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] len;
    logic [11:0] rd_addr;
    logic [3:0]  rd_en;
    logic [31:0] rd_data;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        done;
`ifdef MM2S_BEAT_COUNT_EN
    logic [31:0] beat_count;
`endif

    mm2s_banked #(.D_W(8), .N(4), .ADDR_W(12)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .len                (len),
        .rd_addr            (rd_addr),
        .rd_en              (rd_en),
        .rd_data            (rd_data),
        .m_axis_mm2s_tdata  (tdata),
        .m_axis_mm2s_tvalid (tvalid),
        .m_axis_mm2s_tready (tready),
        .m_axis_mm2s_tlast  (tlast),
        .busy               (busy),
        .done               (done)
`ifdef MM2S_BEAT_COUNT_EN
        ,
        .beat_count         (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read bank model: data one cycle after rd_en.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (rd_en[k]) rd_data[k*8 +: 8] <= 8'(16 * k) + rd_addr[7:0];
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cycle_n  = 0;
    int         beat_n   = 0;
    int         done_n   = 0;
    int         rd_total = 0;
    int         issued   = 0;
    int         popped   = 0;
    int         done_cyc = 0;
    int         last_beat_cyc = 0;
    logic [7:0] beat_dat  [0:511];
    logic       beat_last [0:511];
    logic       stall_prev = 1'b0;
    logic [9:0] stall_word = '0;
    bit         rnd_ready  = 1'b0;
    int         base, rd0, b0, d0;
    logic [31:0] bc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples at the falling edge, then returns just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        cycle_n++;
        if (rst_n) begin
            if (rd_en != 4'd0) begin
                issued++;
                rd_total++;
            end
            if (tvalid && tready) begin
                beat_dat[beat_n]  = tdata;
                beat_last[beat_n] = tlast;
                beat_n++;
                popped++;
                last_beat_cyc = cycle_n;
            end
            if (done) begin
                done_n++;
                done_cyc = cycle_n;
            end
            if (stall_prev) check("stall_hold", 32'({tvalid, tlast, tdata}), 32'(stall_word));
            stall_prev = tvalid && !tready;
            stall_word = {tvalid, tlast, tdata};
            check("rd_en_onehot", 32'($onehot0(rd_en)), 32'd1);
            if (!busy) check("rd_en_idle", 32'(rd_en), 32'd0);
            check("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int dd;
        int g;
        dd = done_n;
        g  = 0;
        while (done_n == dd && g < budget) begin
            if (rnd_ready) tready = 1'($urandom_range(0, 1));
            cyc();
            g++;
        end
        check("done_seen", 32'(done_n - dd), 32'd1);
    endtask

    task automatic check_beats(input string tag, input int b, input int nlen);
        check({tag, "_count"}, 32'(beat_n - b), 32'(nlen * 4));
        for (int i = 0; i < nlen * 4 && b + i < beat_n; i++) begin
            check({tag, "_tdata"}, 32'(beat_dat[b+i]), 32'(16 * (i % 4) + i / 4));
            check({tag, "_tlast"}, 32'(beat_last[b+i]), 32'(i == nlen * 4 - 1));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        len    = 12'd0;
        tready = 1'b1;
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Basic transfer, tready high: latency, order, tlast, done timing.
        base  = beat_n;
        start = 1'b1;
        len   = 12'd3;
        check("pre_accept_busy", 32'(busy), 32'd0);
        cyc();
        start = 1'b0;
        check("acc1_busy", 32'(busy), 32'd1);
        check("acc1_rd_en", 32'(rd_en), 32'd1);
        check("acc1_rd_addr", 32'(rd_addr), 32'd0);
        check("acc1_tvalid", 32'(tvalid), 32'd0);
`ifdef MM2S_BEAT_COUNT_EN
        check("bc_cleared", beat_count, 32'd0);
`endif
        cyc();
        check("acc2_rd_en", 32'(rd_en), 32'd2);
        check("acc2_tvalid", 32'(tvalid), 32'd0);
        cyc();
        check("acc3_tvalid", 32'(tvalid), 32'd1);
        check("acc3_tdata", 32'(tdata), 32'h00);
        wait_done(60);
        check_beats("basic", base, 3);
        check("done_after_last", 32'(done_cyc - last_beat_cyc), 32'd1);
        check("post_done_busy", 32'(busy), 32'd0);
        check("post_done_done", 32'(done), 32'd0);
`ifdef MM2S_BEAT_COUNT_EN
        check("bc_at_done", beat_count, 32'd12);
        repeat (3) cyc();
        check("bc_held", beat_count, 32'd12);
`endif

        // Random backpressure.
        base      = beat_n;
        start     = 1'b1;
        len       = 12'd3;
        cyc();
        start     = 1'b0;
        rnd_ready = 1'b1;
        wait_done(400);
        rnd_ready = 1'b0;
        tready    = 1'b1;
        check_beats("rnd", base, 3);
        cyc();

        // Zero length request.
        rd0   = rd_total;
        b0    = beat_n;
        d0    = done_n;
        start = 1'b1;
        len   = 12'd0;
        cyc();
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_tvalid", 32'(tvalid), 32'd0);
        cyc();
        check("len0_done_off", 32'(done), 32'd0);
        cyc();
        check("len0_no_reads", 32'(rd_total - rd0), 32'd0);
        check("len0_no_beats", 32'(beat_n - b0), 32'd0);
        check("len0_one_pulse", 32'(done_n - d0), 32'd1);

        // Reset after five beats.
        base  = beat_n;
        start = 1'b1;
        len   = 12'd3;
        cyc();
        start = 1'b0;
        for (int g = 0; g < 40 && beat_n - base < 5; g++) cyc();
        check("mid_beats", 32'(beat_n - base), 32'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(tvalid), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        cyc();
        cyc();
        rst_n      = 1'b1;
        issued     = 0;
        popped     = 0;
        stall_prev = 1'b0;
        rd0        = rd_total;
        b0         = beat_n;
        repeat (10) cyc();
        check("post_rst_no_reads", 32'(rd_total - rd0), 32'd0);
        check("post_rst_no_beats", 32'(beat_n - b0), 32'd0);
        base  = beat_n;
        start = 1'b1;
        len   = 12'd3;
        cyc();
        start = 1'b0;
        check("restart_rd_addr", 32'(rd_addr), 32'd0);
        wait_done(60);
        check_beats("restart", base, 3);
        cyc();

        // start held high, len changed while busy.
        base  = beat_n;
        start = 1'b1;
        len   = 12'd3;
        cyc();
        len   = 12'd5;
        wait_done(100);
        check_beats("held", base, 3);
        check("held_gap_busy", 32'(busy), 32'd0);
        base  = beat_n;
        cyc();
        check("second_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(150);
        check_beats("second", base, 5);
        cyc();

`ifdef MM2S_BEAT_COUNT_EN
        // Stalled stream leaves beat_count untouched.
        start = 1'b1;
        len   = 12'd3;
        cyc();
        start = 1'b0;
        base  = beat_n;
        for (int g = 0; g < 40 && beat_n - base < 3; g++) cyc();
        tready = 1'b0;
        #1;
        bc = beat_count;
        check("bc_before_stall", bc, 32'd3);
        repeat (10) cyc();
        check("bc_stalled", beat_count, 32'd3);
        tready = 1'b1;
        wait_done(60);
        check("bc_final", beat_count, 32'd12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
